// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: operation classes, opcodes,
// divider FSM states and the single shift-subtract step of the divider.
package ex_stage_pkg;

    localparam int DIV_ITER_DEFAULT = 32;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b101;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_START  = 2'd1,
        DIV_DIVIDE = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quot;
    } div_step_t;

    // The 33-bit difference is negative exactly when the shifted remainder is below the divisor.
    function automatic div_step_t div_step(input logic [31:0] rem,
                                           input logic [31:0] quot,
                                           input logic [31:0] divisor);
        div_step_t   res;
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted  = {rem, quot[31]};
        diff     = shifted - {1'b0, divisor};
        res.quot = {quot[30:0], ~diff[32]};
        res.rem  = diff[32] ? shifted[31:0] : diff[31:0];
        return res;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic        flush_i;
    logic [2:0]  alusel_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_req_o;

    modport master (
        output flush_i, alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, hi_o, lo_o, stall_req_o
    );

    modport slave (
        input  flush_i, alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, hi_o, lo_o, stall_req_o
    );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider: operands latched in START, one quotient bit per cycle,
// the last bit and the sign fix-up resolve combinationally in DONE.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed_div,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic        i_abort,
    output logic [31:0] o_result_hi,
    output logic [31:0] o_result_lo,
    output logic        o_done,
    output logic        o_busy
);
    localparam int CW = $clog2(DIV_ITER);

    div_state_e    r_state;
    div_state_e    w_next;
    logic [31:0]   r_quot;
    logic [31:0]   r_rem;
    logic [31:0]   r_divisor;
    logic [CW-1:0] r_count;
    logic          r_neg_quot;
    logic          r_neg_rem;
    logic          r_zero_div;
    logic [31:0]   w_op1_abs;
    logic [31:0]   w_op2_abs;
    logic [31:0]   w_quot_fix;
    logic [31:0]   w_rem_fix;
    div_step_t     w_step;

    assign w_op1_abs = (i_signed_div && i_op1[31]) ? (~i_op1 + 32'd1) : i_op1;
    assign w_op2_abs = (i_signed_div && i_op2[31]) ? (~i_op2 + 32'd1) : i_op2;
    assign w_step    = div_step(r_rem, r_quot, r_divisor);

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_next;
    end

    // The IDLE detect cycle already counts as busy so the pipeline holds the DIV in EX.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next = DIV_START;
                    o_busy = 1'b1;
                end
            end
            DIV_START: begin
                o_busy = 1'b1;
                w_next = (i_op2 == 32'd0) ? DIV_DONE : DIV_DIVIDE;
            end
            DIV_DIVIDE: begin
                o_busy = 1'b1;
                if (r_count == CW'(DIV_ITER - 2)) w_next = DIV_DONE;
            end
            DIV_DONE: begin
                o_done = !i_abort;
                w_next = DIV_IDLE;
            end
            default: w_next = DIV_IDLE;
        endcase
        if (i_abort) w_next = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot     <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_zero_div <= 1'b0;
        end else begin
            case (r_state)
                DIV_START: begin
                    r_quot     <= w_op1_abs;
                    r_divisor  <= w_op2_abs;
                    r_rem      <= '0;
                    r_count    <= '0;
                    r_neg_quot <= i_signed_div && (i_op1[31] ^ i_op2[31]);
                    r_neg_rem  <= i_signed_div && i_op1[31];
                    r_zero_div <= (i_op2 == 32'd0);
                end
                DIV_DIVIDE: begin
                    r_quot  <= w_step.quot;
                    r_rem   <= w_step.rem;
                    r_count <= r_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // On divide by zero r_quot still holds |dividend|, so the raw dividend is rebuilt for HI.
    assign w_quot_fix  = r_neg_quot ? (~w_step.quot + 32'd1) : w_step.quot;
    assign w_rem_fix   = r_neg_rem  ? (~w_step.rem + 32'd1)  : w_step.rem;
    assign o_result_lo = r_zero_div ? 32'hFFFF_FFFF : w_quot_fix;
    assign o_result_hi = r_zero_div ? (r_neg_rem ? (~r_quot + 32'd1) : r_quot) : w_rem_fix;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: zero-latency ALU result for EX/MEM and forwarding, HI/LO registers
// and the stalling sequential divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = DIV_ITER_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_result;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;
    logic        w_div_done;
    logic        w_div_busy;
    logic        w_is_div;
    logic        w_signed_div;

    assign w_is_div     = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
    assign w_signed_div = (bus.aluop_i == OP_DIV);

    div_unit #(.DIV_ITER(DIV_ITER)) u_div (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_is_div),
        .i_signed_div (w_signed_div),
        .i_op1        (bus.reg1_i),
        .i_op2        (bus.reg2_i),
        .i_abort      (bus.flush_i),
        .o_result_hi  (w_div_hi),
        .o_result_lo  (w_div_lo),
        .o_done       (w_div_done),
        .o_busy       (w_div_busy)
    );

    always_comb begin
        w_result = '0;
        case (bus.alusel_i)
            SEL_LOGIC: begin
                case (bus.aluop_i)
                    OP_AND:  w_result = bus.reg1_i & bus.reg2_i;
                    OP_OR:   w_result = bus.reg1_i | bus.reg2_i;
                    OP_XOR:  w_result = bus.reg1_i ^ bus.reg2_i;
                    OP_NOR:  w_result = ~(bus.reg1_i | bus.reg2_i);
                    default: w_result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (bus.aluop_i)
                    OP_SLL:  w_result = bus.reg2_i << bus.reg1_i[4:0];
                    OP_SRL:  w_result = bus.reg2_i >> bus.reg1_i[4:0];
                    OP_SRA:  w_result = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
                    default: w_result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (bus.aluop_i)
                    OP_ADDU: w_result = bus.reg1_i + bus.reg2_i;
                    OP_SUBU: w_result = bus.reg1_i - bus.reg2_i;
                    OP_SLT:  w_result = {31'd0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
                    OP_SLTU: w_result = {31'd0, bus.reg1_i < bus.reg2_i};
                    default: w_result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (bus.aluop_i)
                    OP_MFHI: w_result = r_hi;
                    OP_MFLO: w_result = r_lo;
                    default: w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    // Divider completion wins; MTHI/MTLO are held off while the divider owns the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_done) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
        end else if (!w_div_busy && bus.alusel_i == SEL_MOVE) begin
            if (bus.aluop_i == OP_MTHI) r_hi <= bus.reg1_i;
            if (bus.aluop_i == OP_MTLO) r_lo <= bus.reg1_i;
        end
    end

    assign bus.wd_o        = rst ? 5'd0  : bus.wd_i;
    assign bus.wreg_o      = rst ? 1'b0  : bus.wreg_i;
    assign bus.wdata_o     = rst ? 32'd0 : w_result;
    assign bus.stall_req_o = rst ? 1'b0  : w_div_busy;
    assign bus.hi_o        = r_hi;
    assign bus.lo_o        = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU classes, HI/LO moves, divider latency,
// divide by zero, and flush/reset aborting a divide.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   testsRun    = 0;
    int   testsFailed = 0;

    ex_stage_if bus();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] op,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [4:0] wd, input logic wreg);
        bus.alusel_i = sel;
        bus.aluop_i  = op;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
    endtask

    // Issues a divide, counts stalled cycles (bounded), records wdata in the DONE cycle,
    // then retires it past the HI/LO write edge.
    task automatic runDiv(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                          output int stallCycles, output logic [31:0] doneWdata);
        @(negedge clk);
        applyStimulus(SEL_DIV, op, r1, r2, 5'd0, 1'b0);
        stallCycles = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!bus.stall_req_o) break;
            stallCycles++;
            @(negedge clk);
        end
        doneWdata = bus.wdata_o;
        applyStimulus(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_i = 1'b0;
        applyStimulus(SEL_LOGIC, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd5, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (bus.wdata_o !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_wdata got=%h exp=0", bus.wdata_o); end
        testsRun++;
        if (bus.wd_o !== 5'd0 || bus.wreg_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wd got=%0d/%b exp=0/0", bus.wd_o, bus.wreg_o); end
        testsRun++;
        if (bus.stall_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.stall_req_o); end
        testsRun++;
        if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_hilo got=%h/%h exp=0/0", bus.hi_o, bus.lo_o); end
        rst = 1'b0;
    endtask

    task automatic test_logic();
        vec_t vecs[4];
        @(negedge clk);
        applyStimulus(SEL_LOGIC, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd5, 1'b1);
        #1;
        testsRun++;
        if (bus.wdata_o !== 32'hF00FF00F) begin testsFailed++; $display("[TB] FAIL xor_wdata got=%h exp=F00FF00F", bus.wdata_o); end
        testsRun++;
        if (bus.wd_o !== 5'd5 || bus.wreg_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL xor_wd got=%0d/%b exp=5/1", bus.wd_o, bus.wreg_o); end
        testsRun++;
        if (bus.stall_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL xor_stall got=%b exp=0", bus.stall_req_o); end
        vecs[0] = '{SEL_LOGIC, OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
        vecs[1] = '{SEL_LOGIC, OP_OR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F};
        vecs[2] = '{SEL_LOGIC, OP_NOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0};
        vecs[3] = '{SEL_LOGIC, 8'hFF,  32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000};
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].r1, vecs[i].r2, 5'd1, 1'b1);
            #1;
            testsRun++;
            if (bus.wdata_o !== vecs[i].exp) begin testsFailed++; $display("[TB] FAIL logic_%0d got=%h exp=%h", i, bus.wdata_o, vecs[i].exp); end
        end
    endtask

    task automatic test_shift();
        vec_t vecs[4];
        vecs[0] = '{SEL_SHIFT, OP_SRA, 32'd4,  32'h80000010, 32'hF8000001};
        vecs[1] = '{SEL_SHIFT, OP_SRL, 32'd4,  32'h80000010, 32'h08000001};
        vecs[2] = '{SEL_SHIFT, OP_SLL, 32'd4,  32'h80000010, 32'h00000100};
        vecs[3] = '{SEL_SHIFT, OP_SLL, 32'h21, 32'h00000001, 32'h00000002};
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].r1, vecs[i].r2, 5'd2, 1'b1);
            #1;
            testsRun++;
            if (bus.wdata_o !== vecs[i].exp) begin testsFailed++; $display("[TB] FAIL shift_%0d got=%h exp=%h", i, bus.wdata_o, vecs[i].exp); end
        end
    endtask

    task automatic test_arith();
        vec_t vecs[6];
        vecs[0] = '{SEL_ARITH, OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1};
        vecs[1] = '{SEL_ARITH, OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[2] = '{SEL_ARITH, OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1};
        vecs[3] = '{SEL_ARITH, OP_ADDU, 32'hFFFFFFFF, 32'd2,        32'd1};
        vecs[4] = '{SEL_ARITH, OP_SUBU, 32'd0,        32'd1,        32'hFFFFFFFF};
        vecs[5] = '{SEL_NOP,   OP_ADDU, 32'd3,        32'd4,        32'd0};
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].r1, vecs[i].r2, 5'd3, 1'b1);
            #1;
            testsRun++;
            if (bus.wdata_o !== vecs[i].exp) begin testsFailed++; $display("[TB] FAIL arith_%0d got=%h exp=%h", i, bus.wdata_o, vecs[i].exp); end
        end
    endtask

    task automatic test_move();
        @(negedge clk);
        applyStimulus(SEL_MOVE, OP_MTHI, 32'h12345678, 32'd0, 5'd0, 1'b0);
        #1;
        testsRun++;
        if (bus.wdata_o !== 32'd0) begin testsFailed++; $display("[TB] FAIL mthi_wdata got=%h exp=0", bus.wdata_o); end
        @(negedge clk);
        applyStimulus(SEL_MOVE, OP_MFHI, 32'd0, 32'd0, 5'd4, 1'b1);
        #1;
        testsRun++;
        if (bus.wdata_o !== 32'h12345678) begin testsFailed++; $display("[TB] FAIL mfhi_wdata got=%h exp=12345678", bus.wdata_o); end
        testsRun++;
        if (bus.hi_o !== 32'h12345678) begin testsFailed++; $display("[TB] FAIL mthi_hi got=%h exp=12345678", bus.hi_o); end
        @(negedge clk);
        applyStimulus(SEL_MOVE, OP_MTLO, 32'hCAFEF00D, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        applyStimulus(SEL_MOVE, OP_MFLO, 32'd0, 32'd0, 5'd4, 1'b1);
        #1;
        testsRun++;
        if (bus.wdata_o !== 32'hCAFEF00D || bus.hi_o !== 32'h12345678) begin
            testsFailed++; $display("[TB] FAIL mflo_wdata got=%h hi=%h exp=CAFEF00D hi=12345678", bus.wdata_o, bus.hi_o);
        end
    endtask

    task automatic test_div();
        int          stalls;
        logic [31:0] doneWdata;
        runDiv(OP_DIV, 32'hFFFFFFF9, 32'd2, stalls, doneWdata);
        testsRun++;
        if (stalls != 33) begin testsFailed++; $display("[TB] FAIL div_stall_cycles got=%0d exp=33", stalls); end
        testsRun++;
        if (doneWdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL div_done_wdata got=%h exp=0", doneWdata); end
        testsRun++;
        if (bus.lo_o !== 32'hFFFFFFFD || bus.hi_o !== 32'hFFFFFFFF) begin
            testsFailed++; $display("[TB] FAIL div_signed got lo=%h hi=%h exp lo=FFFFFFFD hi=FFFFFFFF", bus.lo_o, bus.hi_o);
        end
        runDiv(OP_DIVU, 32'd100, 32'd7, stalls, doneWdata);
        testsRun++;
        if (stalls != 33) begin testsFailed++; $display("[TB] FAIL divu_stall_cycles got=%0d exp=33", stalls); end
        testsRun++;
        if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin
            testsFailed++; $display("[TB] FAIL divu got lo=%0d hi=%0d exp lo=14 hi=2", bus.lo_o, bus.hi_o);
        end
        @(negedge clk);
        applyStimulus(SEL_MOVE, OP_MFLO, 32'd0, 32'd0, 5'd6, 1'b1);
        #1;
        testsRun++;
        if (bus.wdata_o !== 32'd14) begin testsFailed++; $display("[TB] FAIL divu_mflo got=%0d exp=14", bus.wdata_o); end
    endtask

    task automatic test_div_zero();
        int          stalls;
        logic [31:0] doneWdata;
        runDiv(OP_DIVU, 32'd9, 32'd0, stalls, doneWdata);
        testsRun++;
        if (stalls != 2) begin testsFailed++; $display("[TB] FAIL divzero_stall_cycles got=%0d exp=2", stalls); end
        testsRun++;
        if (bus.lo_o !== 32'hFFFFFFFF || bus.hi_o !== 32'd9) begin
            testsFailed++; $display("[TB] FAIL divuzero got lo=%h hi=%h exp lo=FFFFFFFF hi=9", bus.lo_o, bus.hi_o);
        end
        runDiv(OP_DIV, 32'hFFFFFFFB, 32'd0, stalls, doneWdata);
        testsRun++;
        if (bus.lo_o !== 32'hFFFFFFFF || bus.hi_o !== 32'hFFFFFFFB) begin
            testsFailed++; $display("[TB] FAIL divzero_signed got lo=%h hi=%h exp lo=FFFFFFFF hi=FFFFFFFB", bus.lo_o, bus.hi_o);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        applyStimulus(SEL_DIV, OP_DIV, 32'd1000, 32'd3, 5'd0, 1'b0);
        repeat (12) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        applyStimulus(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        testsRun++;
        if (bus.stall_req_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_stall got=%b exp=0", bus.stall_req_o); end
        repeat (40) @(negedge clk);
        testsRun++;
        if (bus.lo_o !== 32'hFFFFFFFF || bus.hi_o !== 32'hFFFFFFFB) begin
            testsFailed++; $display("[TB] FAIL flush_hilo got lo=%h hi=%h exp lo=FFFFFFFF hi=FFFFFFFB", bus.lo_o, bus.hi_o);
        end
    endtask

    task automatic test_reset_div();
        @(negedge clk);
        applyStimulus(SEL_DIV, OP_DIVU, 32'd1000, 32'd3, 5'd7, 1'b1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        testsRun++;
        if (bus.stall_req_o !== 1'b0 || bus.wdata_o !== 32'd0 || bus.wd_o !== 5'd0 || bus.wreg_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rstdiv_outputs got stall=%b wdata=%h wd=%0d wreg=%b exp all 0",
                     bus.stall_req_o, bus.wdata_o, bus.wd_o, bus.wreg_o);
        end
        @(negedge clk);
        testsRun++;
        if (bus.lo_o !== 32'd0 || bus.hi_o !== 32'd0) begin
            testsFailed++; $display("[TB] FAIL rstdiv_hilo got lo=%h hi=%h exp 0/0", bus.lo_o, bus.hi_o);
        end
        applyStimulus(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        testsRun++;
        if (bus.stall_req_o !== 1'b0 || bus.lo_o !== 32'd0 || bus.hi_o !== 32'd0) begin
            testsFailed++; $display("[TB] FAIL rstdiv_after got stall=%b lo=%h hi=%h exp 0", bus.stall_req_o, bus.lo_o, bus.hi_o);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_arith();
        test_move();
        test_div();
        test_div_zero();
        test_flush();
        test_reset_div();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
